// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants, uo_out pin map and shared types for the VGA beam scheduler.
`timescale 1ns/1ps
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FRONT  = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BACK   = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FRONT  = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BACK   = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned PIN_HS = 7;
  localparam int unsigned PIN_VS = 3;
  localparam int unsigned PIN_R1 = 0;
  localparam int unsigned PIN_R0 = 4;
  localparam int unsigned PIN_G1 = 1;
  localparam int unsigned PIN_G0 = 5;
  localparam int unsigned PIN_B1 = 2;
  localparam int unsigned PIN_B0 = 6;

  typedef logic [1:0] rgb2_t;

  typedef struct packed {
    rgb2_t r;
    rgb2_t g;
    rgb2_t b;
  } rgb_t;

  typedef struct packed {
    logic hsync_n;
    logic vsync_n;
    logic de;
  } timing_t;

  localparam timing_t TIMING_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, de: 1'b0};

  function automatic logic [7:0] pack_uo(input timing_t t, input rgb_t c);
    logic [7:0] uo;
    uo         = '0;
    uo[PIN_HS] = t.hsync_n;
    uo[PIN_VS] = t.vsync_n;
    uo[PIN_R1] = c.r[1];
    uo[PIN_R0] = c.r[0];
    uo[PIN_G1] = c.g[1];
    uo[PIN_G0] = c.g[0];
    uo[PIN_B1] = c.b[1];
    uo[PIN_B0] = c.b[0];
    return uo;
  endfunction

endpackage

// File: rtl/vga_beam_counter.sv
// Master beam counters: x/y position, wrap, and the sync/de/frame-origin decode for that position.
`timescale 1ns/1ps
module vga_beam_counter #(
  parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FRONT  = vga_timing_pkg::H_FRONT,
  parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BACK   = vga_timing_pkg::H_BACK,
  parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FRONT  = vga_timing_pkg::V_FRONT,
  parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BACK   = vga_timing_pkg::V_BACK
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_de,
  output logic       o_hsync_n,
  output logic       o_vsync_n,
  output logic       o_origin
);
  import vga_timing_pkg::*;

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [CNT_W-1:0] X_VIS  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] Y_VIS  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] X_SS   = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] X_SE   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] Y_SS   = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] Y_SE   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             w_x_wrap;
  logic             w_y_wrap;

  assign w_x_wrap = (r_x == X_LAST);
  assign w_y_wrap = (r_y == Y_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_x_wrap) begin
      r_x <= '0;
      r_y <= w_y_wrap ? '0 : r_y + 1'b1;
    end else begin
      r_x <= r_x + 1'b1;
    end
  end

  assign o_x       = r_x;
  assign o_y       = r_y;
  assign o_de      = (r_x < X_VIS) && (r_y < Y_VIS);
  assign o_hsync_n = !((r_x >= X_SS) && (r_x < X_SE));
  assign o_vsync_n = !((r_y >= Y_SS) && (r_y < Y_SE));
  assign o_origin  = (r_x == '0) && (r_y == '0);

endmodule

// File: rtl/vga_beam_scheduler.sv
// Issues pixel requests LEAD cycles ahead of display, re-aligns syncs with pipeline colour and
// commits scene configuration only at frame boundaries.
`timescale 1ns/1ps
module vga_beam_scheduler #(
  parameter int unsigned LEAD     = 2,
  parameter int unsigned CFG_W    = 8,
  parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FRONT  = vga_timing_pkg::H_FRONT,
  parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BACK   = vga_timing_pkg::H_BACK,
  parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FRONT  = vga_timing_pkg::V_FRONT,
  parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BACK   = vga_timing_pkg::V_BACK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  input  logic [CFG_W-1:0] cfg_data,
  output logic             cfg_ready,
  output logic [CFG_W-1:0] cfg_active,
  output logic             req_valid,
  output logic [9:0]       req_x,
  output logic [9:0]       req_y,
  output logic             frame_start,
  input  logic [5:0]       px_rgb,
  output logic [7:0]       uo_out
);
  import vga_timing_pkg::*;

  logic [9:0] w_x;
  logic [9:0] w_y;
  logic       w_de;
  logic       w_hs_n;
  logic       w_vs_n;
  logic       w_origin;

  vga_beam_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK)
  ) u_beam (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .o_x       (w_x),
    .o_y       (w_y),
    .o_de      (w_de),
    .o_hsync_n (w_hs_n),
    .o_vsync_n (w_vs_n),
    .o_origin  (w_origin)
  );

  // Counters sit at (0,0) during reset, so the request strobes are masked until release.
  assign req_x       = w_x;
  assign req_y       = w_y;
  assign req_valid   = rst_n && w_de;
  assign frame_start = rst_n && w_origin;

  // LEAD-1 timing stages here; the output register supplies the last stage.
  timing_t w_tap [LEAD];

  assign w_tap[0] = '{hsync_n: w_hs_n, vsync_n: w_vs_n, de: w_de};

  for (genvar gi = 1; gi < LEAD; gi++) begin : g_dly
    timing_t r_stage;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_stage <= TIMING_IDLE;
      end else begin
        r_stage <= w_tap[gi-1];
      end
    end

    assign w_tap[gi] = r_stage;
  end

  logic [7:0] r_uo;
  rgb_t       w_rgb;

  assign w_rgb = w_tap[LEAD-1].de ? rgb_t'(px_rgb) : rgb_t'('0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_uo <= pack_uo(TIMING_IDLE, rgb_t'('0));
    end else begin
      r_uo <= pack_uo(w_tap[LEAD-1], w_rgb);
    end
  end

  assign uo_out = r_uo;

  logic             r_pend_valid;
  logic [CFG_W-1:0] r_pend;
  logic [CFG_W-1:0] r_active;
  logic             w_cfg_ready;
  logic             w_xfer;

  // The slot empties at the frame origin, so a word offered on that cycle queues for the next frame.
  assign w_cfg_ready = !r_pend_valid || w_origin;
  assign w_xfer      = cfg_valid && w_cfg_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_valid <= 1'b0;
      r_pend       <= '0;
      r_active     <= '0;
    end else begin
      if (w_origin && r_pend_valid) begin
        r_active <= r_pend;
      end
      if (w_xfer) begin
        r_pend_valid <= 1'b1;
        r_pend       <= cfg_data;
      end else if (w_origin) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  assign cfg_ready  = w_cfg_ready;
  assign cfg_active = r_active;

endmodule

// File: tb/tb_vga_beam_scheduler.sv
// Directed bench: four full-timing schedulers (LEAD 2,1,4,8) plus a shrunken-timing one for frame work.
`timescale 1ns/1ps
module tb_vga_beam_scheduler;

  localparam int NDUT = 4;
  localparam int NCYC = 1762;

  function automatic int lead_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      2:       return 4;
      default: return 8;
    endcase
  endfunction

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_data = 8'h00;

  logic [5:0] px  [NDUT];
  logic [7:0] uo  [NDUT];
  logic [7:0] act [NDUT];
  logic       rdy [NDUT];
  logic       rv  [NDUT];
  logic       fs  [NDUT];
  logic [9:0] rx  [NDUT];
  logic [9:0] ry  [NDUT];

  logic [5:0] px_sm = 6'h15;
  logic [7:0] uo_sm, act_sm;
  logic       rdy_sm, rv_sm, fs_sm;
  logic [9:0] rx_sm, ry_sm;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    vga_beam_scheduler #(.LEAD(lead_of(g))) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_valid   (cfg_valid),
      .cfg_data    (cfg_data),
      .cfg_ready   (rdy[g]),
      .cfg_active  (act[g]),
      .req_valid   (rv[g]),
      .req_x       (rx[g]),
      .req_y       (ry[g]),
      .frame_start (fs[g]),
      .px_rgb      (px[g]),
      .uo_out      (uo[g])
    );
  end

  // 24 x 10 frame: H 16/2/4/2, V 6/1/2/1.
  vga_beam_scheduler #(
    .LEAD(2), .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u_sm (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_data    (cfg_data),
    .cfg_ready   (rdy_sm),
    .cfg_active  (act_sm),
    .req_valid   (rv_sm),
    .req_x       (rx_sm),
    .req_y       (ry_sm),
    .frame_start (fs_sm),
    .px_rgb      (px_sm),
    .uo_out      (uo_sm)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  bit force_hist [0:2047];

  function automatic logic [7:0] pin(input logic hs, input logic vs, input logic [5:0] c);
    logic [7:0] u;
    u = 8'h00;
    u[7] = hs; u[3] = vs;
    u[0] = c[5]; u[4] = c[4]; u[1] = c[3]; u[5] = c[2]; u[2] = c[1]; u[6] = c[0];
    return u;
  endfunction

  // Expected pin state in cycle c for a LEAD-L instance: shows the request of cycle c-L.
  function automatic logic [7:0] exp_full(input int c, input int L);
    int x, y;
    logic de;
    logic [5:0] c6;
    if (c < L) return 8'h88;
    x  = (c - L) % 800;
    y  = ((c - L) / 800) % 525;
    de = (x < 640) && (y < 480);
    c6 = !de ? 6'h00 : (force_hist[c-1] ? 6'h3F : 6'(x % 64));
    return pin(!(x >= 656 && x < 752), !(y >= 490 && y < 492), c6);
  endfunction

  int f1 [NDUT], r1 [NDUT], f2 [NDUT], off1 [NDUT], lastz [NDUT], nfall [NDUT], err [NDUT];
  logic [7:0] prev [NDUT];
  int beam_err = 0;
  int vs_f1 = -1, vs_r1 = -1, vs_f2 = -1;
  logic vs_prev = 1'b1;

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      f1[k] = -1; r1[k] = -1; f2[k] = -1; off1[k] = -1; lastz[k] = -1;
      nfall[k] = 0; err[k] = 0; prev[k] = 8'h88; px[k] = 6'h00;
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_uo", uo[0], 8'h88);
    check("rst_req_valid", rv[0], 0);
    check("rst_frame_start", fs[0], 0);
    check("rst_cfg_ready", rdy[0], 1);
    check("rst_cfg_active", act[0], 0);
    check("rst_uo_lead8", uo[3], 8'h88);

    rst_n = 1'b1;
    #1;
    check("fs_after_release", fs[0], 1);
    check("fs_after_release_sm", fs_sm, 1);

    for (int c = 0; c < NCYC; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      force_hist[c] = (c >= 1000 && c < 1700);

      for (int k = 0; k < NDUT; k++) begin
        int L;
        L = lead_of(k);
        if (uo[k] !== exp_full(c, L)) err[k]++;
        if ((|(prev[k] & 8'h77)) && !(|(uo[k] & 8'h77))) lastz[k] = c;
        if (prev[k][7] && !uo[k][7]) begin
          if (nfall[k] == 0) begin
            f1[k] = c;
            off1[k] = c - lastz[k];
          end else if (nfall[k] == 1) begin
            f2[k] = c;
          end
          nfall[k]++;
        end
        if (!prev[k][7] && uo[k][7] && r1[k] < 0) r1[k] = c;
        prev[k] = uo[k];
        if (force_hist[c]) px[k] = 6'h3F;
        else if (c >= L - 1) px[k] = 6'((c - L + 1) % 800 % 64);
        else px[k] = 6'h00;
      end

      if (rx[0] !== 10'(c % 800) || ry[0] !== 10'(c / 800) ||
          rv[0] !== ((c % 800) < 640 && (c / 800) < 480) || fs[0] !== (c == 0)) beam_err++;

      if (vs_prev && !uo_sm[3]) begin
        if (vs_f1 < 0) vs_f1 = c;
        else if (vs_f2 < 0) vs_f2 = c;
      end
      if (!vs_prev && uo_sm[3] && vs_r1 < 0) vs_r1 = c;
      vs_prev = uo_sm[3];

      if (c == 50) begin
        check("cfg_ready_idle", rdy_sm, 1);
        cfg_valid = 1'b1;
        cfg_data  = 8'hA5;
      end
      if (c == 51) begin
        check("cfg_ready_after_accept", rdy_sm, 0);
        check("cfg_active_not_yet", act_sm, 8'h00);
        cfg_data = 8'h3C;
      end
      if (c == 120) begin
        check("cfg_second_stalled", rdy_sm, 0);
        check("cfg_active_midframe", act_sm, 8'h00);
      end
      if (c == 240) begin
        check("sm_frame_start", fs_sm, 1);
        check("cfg_ready_at_commit", rdy_sm, 1);
      end
      if (c == 241) begin
        check("cfg_active_a5", act_sm, 8'hA5);
        check("cfg_3c_accepted", rdy_sm, 0);
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
      end
      if (c == 300) begin
        cfg_valid = 1'b1;
        cfg_data  = 8'h77;
      end
      if (c == 310) begin
        check("cfg_offer_stalled", rdy_sm, 0);
        cfg_valid = 1'b0;
        cfg_data  = 8'hEE;
      end
      if (c == 481) begin
        check("cfg_active_3c", act_sm, 8'h3C);
        check("cfg_no_sticky", rdy_sm, 1);
      end
      if (c == 1500) check("blank_with_3f", uo[0] & 8'h77, 8'h00);
      if (c == 1755) begin
        cfg_valid = 1'b1;
        cfg_data  = 8'h5A;
      end
      if (c == 1756) begin
        check("slot_full_before_reset", rdy_sm, 0);
        cfg_valid = 1'b0;
      end
    end

    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("align_errors_lead%0d", lead_of(k)), err[k], 0);
      check($sformatf("hs_first_fall_lead%0d", lead_of(k)), f1[k], 656 + lead_of(k));
      check($sformatf("hs_width_lead%0d", lead_of(k)), r1[k] - f1[k], 96);
      check($sformatf("hs_period_lead%0d", lead_of(k)), f2[k] - f1[k], 800);
      check($sformatf("hs_after_de_lead%0d", lead_of(k)), off1[k], 16);
    end
    check("beam_errors", beam_err, 0);
    check("vs_width_sm", vs_r1 - vs_f1, 48);
    check("vs_period_sm", vs_f2 - vs_f1, 240);

    // Mid-frame reset with the small instance at (10,3) and its slot holding 5A.
    @(posedge clk);
    #1;
    check("sm_pos_x_before_reset", rx_sm, 10);
    check("sm_pos_y_before_reset", ry_sm, 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_uo", uo_sm, 8'h88);
    check("mid_rst_req_valid", rv_sm, 0);
    check("mid_rst_frame_start", fs_sm, 0);
    check("mid_rst_cfg_ready", rdy_sm, 1);
    check("mid_rst_cfg_active", act_sm, 8'h00);
    check("mid_rst_req_x", rx_sm, 0);
    check("mid_rst_uo_full", uo[0], 8'h88);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("fs_after_rerelease", fs_sm, 1);
    check("ready_after_rerelease", rdy_sm, 1);
    repeat (240) @(posedge clk);
    #1;
    check("sm_frame_start_after_reset", fs_sm, 1);
    @(posedge clk);
    #1;
    check("pending_discarded", act_sm, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
